// File: rtl/uaz_bus_pkg.sv
// Shared types and defaults for the MicroUAZ8 data-bus master port.
//   UAZ_DATA_W / UAZ_ADDR_W : default data and address widths
//   TO_CNT_W                : watchdog counter width (limit range 1..255)
//   state_e                 : transaction FSM states
//   op_e                    : transaction op encoding (load / store)
package uaz_bus_pkg;

    localparam int unsigned UAZ_DATA_W = 8;
    localparam int unsigned UAZ_ADDR_W = 8;
    localparam int unsigned TO_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } op_e;

endpackage : uaz_bus_pkg

// File: rtl/bus_timeout_ctr.sv
// Watchdog counter for a bus transaction.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous counter clear (held while not waiting on the bus)
//   enable     : count one cycle per edge
//   limit      : number of enabled cycles allowed (1..255)
//   expire_c   : combinational, high during the limit-th enabled cycle so that the
//                abort lands on the same edge an ack in that cycle would
module bus_timeout_ctr
    import uaz_bus_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                enable,
    input  logic [TO_CNT_W-1:0] limit,
    output logic                expire_c
);

    logic [TO_CNT_W-1:0] cnt_q;

    // cnt_q holds the number of enabled cycles already completed
    assign expire_c = enable && (cnt_q == (limit - TO_CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expire_c) begin
            cnt_q <= cnt_q + TO_CNT_W'(1);
        end
    end

endmodule : bus_timeout_ctr

// File: rtl/bus_data_port.sv
// Data-bus master port of the MicroUAZ8 core: one load/store per request, ack handshake.
// Loaded bytes are registered on o_Dato_Bus for the data-write select stage.
// Optional watchdog: define BUS_TIMEOUT_EN to abort a transaction after TO_CYC REQ cycles
// without ack (o_Err set); otherwise REQ waits for ack indefinitely and o_Err stays 0.
// Ports:
//   i_Clk, i_Rst_n                 clock, async active-low reset
//   i_Req, i_We, i_Addr, i_Wdata   request, sampled in IDLE only
//   o_Busy, o_Done, o_Err          status (Done is a 1-cycle pulse)
//   o_Dato_Bus                     last successfully loaded byte
//   o_Bus_Addr, o_Bus_Wdata        bus address / write data, stable through REQ
//   o_Bus_Rd, o_Bus_Wr             bus strobes
//   i_Bus_Rdata, i_Bus_Ack         bus response
module bus_data_port
    import uaz_bus_pkg::*;
#(
    parameter int unsigned DATA_W = UAZ_DATA_W,
    parameter int unsigned ADDR_W = UAZ_ADDR_W,
    parameter int unsigned TO_CYC = 15
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Req,
    input  logic              i_We,
    input  logic [ADDR_W-1:0] i_Addr,
    input  logic [DATA_W-1:0] i_Wdata,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Err,
    output logic [DATA_W-1:0] o_Dato_Bus,
    output logic [ADDR_W-1:0] o_Bus_Addr,
    output logic [DATA_W-1:0] o_Bus_Wdata,
    output logic              o_Bus_Rd,
    output logic              o_Bus_Wr,
    input  logic [DATA_W-1:0] i_Bus_Rdata,
    input  logic              i_Bus_Ack
);

    if ((TO_CYC < 1) || (TO_CYC > 255)) begin : g_bad_to_cyc
        $error("bus_data_port: TO_CYC must be in 1..255");
    end

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic              busy_d, done_d, err_d, rd_d, wr_d;
    logic [DATA_W-1:0] dato_d, wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic              timeout_c;

`ifdef BUS_TIMEOUT_EN
    // Watchdog runs only while waiting in REQ and restarts on every transaction
    bus_timeout_ctr u_timeout (
        .clk      (i_Clk),
        .rst_n    (i_Rst_n),
        .clear    (state_q != REQ),
        .enable   (state_q == REQ),
        .limit    (TO_CNT_W'(TO_CYC)),
        .expire_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // State and all outputs are registered here
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_LD;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Err       <= 1'b0;
            o_Dato_Bus  <= '0;
            o_Bus_Addr  <= '0;
            o_Bus_Wdata <= '0;
            o_Bus_Rd    <= 1'b0;
            o_Bus_Wr    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            o_Busy      <= busy_d;
            o_Done      <= done_d;
            o_Err       <= err_d;
            o_Dato_Bus  <= dato_d;
            o_Bus_Addr  <= addr_d;
            o_Bus_Wdata <= wdata_d;
            o_Bus_Rd    <= rd_d;
            o_Bus_Wr    <= wr_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        busy_d  = o_Busy;
        done_d  = 1'b0;
        err_d   = o_Err;
        dato_d  = o_Dato_Bus;
        addr_d  = o_Bus_Addr;
        wdata_d = o_Bus_Wdata;
        rd_d    = 1'b0;
        wr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_Req) begin
                    state_d = REQ;
                    op_d    = op_e'(i_We);
                    addr_d  = i_Addr;
                    wdata_d = i_Wdata;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    rd_d    = !i_We;
                    wr_d    = i_We;
                end
            end
            REQ: begin
                rd_d = o_Bus_Rd;
                wr_d = o_Bus_Wr;
                // Ack takes priority over a same-edge watchdog expiry
                if (i_Bus_Ack) begin
                    if (op_q == OP_LD) begin
                        dato_d = i_Bus_Rdata;
                    end
                    state_d = DONE;
                    done_d  = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (timeout_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule : bus_data_port

// File: tb/tb_bus_data_port.sv
// Self-checking bench for bus_data_port: transaction-level reference model compared
// against the DUT every cycle, plus directed literal checks.
module tb_bus_data_port;

    localparam int TO_CYC = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_Req = 1'b0;
    logic       i_We = 1'b0;
    logic [7:0] i_Addr = '0;
    logic [7:0] i_Wdata = '0;
    logic [7:0] i_Bus_Rdata = '0;
    logic       i_Bus_Ack = 1'b0;
    logic       o_Busy, o_Done, o_Err, o_Bus_Rd, o_Bus_Wr;
    logic [7:0] o_Dato_Bus, o_Bus_Addr, o_Bus_Wdata;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    bus_data_port #(.DATA_W(8), .ADDR_W(8), .TO_CYC(TO_CYC)) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Req       (i_Req),
        .i_We        (i_We),
        .i_Addr      (i_Addr),
        .i_Wdata     (i_Wdata),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Err       (o_Err),
        .o_Dato_Bus  (o_Dato_Bus),
        .o_Bus_Addr  (o_Bus_Addr),
        .o_Bus_Wdata (o_Bus_Wdata),
        .o_Bus_Rd    (o_Bus_Rd),
        .o_Bus_Wr    (o_Bus_Wr),
        .i_Bus_Rdata (i_Bus_Rdata),
        .i_Bus_Ack   (i_Bus_Ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is either waiting on the bus, finishing, or absent
    logic       m_waiting, m_finishing, m_err, m_store;
    logic [7:0] m_dato, m_addr, m_wdata;
    int         m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_waiting   <= 1'b0;
            m_finishing <= 1'b0;
            m_err       <= 1'b0;
            m_store     <= 1'b0;
            m_dato      <= '0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wait      <= 0;
        end else if (m_finishing) begin
            m_finishing <= 1'b0;
        end else if (m_waiting) begin
            m_wait <= m_wait + 1;
            if (i_Bus_Ack) begin
                if (!m_store) m_dato <= i_Bus_Rdata;
                m_waiting   <= 1'b0;
                m_finishing <= 1'b1;
            end
`ifdef BUS_TIMEOUT_EN
            else if (m_wait + 1 == TO_CYC) begin
                m_err       <= 1'b1;
                m_waiting   <= 1'b0;
                m_finishing <= 1'b1;
            end
`endif
        end else if (i_Req) begin
            m_waiting <= 1'b1;
            m_wait    <= 0;
            m_store   <= i_We;
            m_addr    <= i_Addr;
            m_wdata   <= i_Wdata;
            m_err     <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("busy",  32'(o_Busy),      32'(m_waiting || m_finishing));
            chk("done",  32'(o_Done),      32'(m_finishing));
            chk("err",   32'(o_Err),       32'(m_err));
            chk("rd",    32'(o_Bus_Rd),    32'(m_waiting && !m_store));
            chk("wr",    32'(o_Bus_Wr),    32'(m_waiting && m_store));
            chk("dato",  32'(o_Dato_Bus),  32'(m_dato));
            chk("addr",  32'(o_Bus_Addr),  32'(m_addr));
            chk("wdata", 32'(o_Bus_Wdata), 32'(m_wdata));
        end
    end

    // Strobe / done cycle counters for directed checks
    always @(negedge clk) begin
        if (o_Bus_Rd === 1'b1) rd_cnt++;
        if (o_Bus_Wr === 1'b1) wr_cnt++;
        if (o_Done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One transaction with 'waits' cycles before ack; checks done latency and strobe length
    task automatic do_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rdata, input int waits, input string tag);
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        tick();
        i_Req = 1'b1; i_We = we; i_Addr = addr; i_Wdata = wdata;
        tick();
        i_Req = 1'b0;
        repeat (waits) tick();
        i_Bus_Ack = 1'b1; i_Bus_Rdata = rdata;
        tick();
        i_Bus_Ack = 1'b0;
        chk({tag, "_done"}, 32'(o_Done), 32'd1);
        if (we) chk({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), 32'(waits + 1));
        else    chk({tag, "_rd_cycles"}, 32'(rd_cnt - rd0), 32'(waits + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int n;
        int rd0;
        // Reset values
        #3;
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_done", 32'(o_Done), 32'd0);
        chk("rst_err",  32'(o_Err), 32'd0);
        chk("rst_dato", 32'(o_Dato_Bus), 32'd0);
        chk("rst_addr", 32'(o_Bus_Addr), 32'd0);
        chk("rst_wdat", 32'(o_Bus_Wdata), 32'd0);
        chk("rst_strb", 32'({o_Bus_Rd, o_Bus_Wr}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // 1: zero-wait load
        do_txn(1'b0, 8'h3C, 8'h00, 8'hA5, 0, "t1");
        chk("t1_dato", 32'(o_Dato_Bus), 32'hA5);
        tick();
        chk("t1_idle_busy", 32'(o_Busy), 32'd0);

        // 2: store with 4 wait cycles, load data untouched
        do_txn(1'b1, 8'h10, 8'h5A, 8'hFF, 4, "t2");
        chk("t2_addr",  32'(o_Bus_Addr), 32'h10);
        chk("t2_wdata", 32'(o_Bus_Wdata), 32'h5A);
        chk("t2_dato",  32'(o_Dato_Bus), 32'hA5);
        tick();

        // 3: request while busy and stray ack in IDLE are ignored
        d0 = done_cnt;
        tick();
        i_Req = 1'b1; i_We = 1'b0; i_Addr = 8'h21;
        tick();
        i_Req = 1'b0;
        tick();
        i_Req = 1'b1; i_We = 1'b1; i_Addr = 8'hEE; i_Wdata = 8'h99;
        tick();
        i_Req = 1'b0; i_Bus_Ack = 1'b1; i_Bus_Rdata = 8'h3D;
        tick();
        i_Bus_Ack = 1'b0;
        chk("t3_done", 32'(o_Done), 32'd1);
        i_Req = 1'b1; i_We = 1'b1; i_Addr = 8'hEF;
        tick();
        i_Req = 1'b0; i_Bus_Ack = 1'b1; i_Bus_Rdata = 8'h11;
        tick(); tick();
        i_Bus_Ack = 1'b0;
        tick();
        chk("t3_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t3_busy", 32'(o_Busy), 32'd0);
        chk("t3_dato", 32'(o_Dato_Bus), 32'h3D);
        chk("t3_addr", 32'(o_Bus_Addr), 32'h21);

        // 4: async reset in REQ drops strobes without a clock edge
        tick();
        i_Req = 1'b1; i_We = 1'b1; i_Addr = 8'h55; i_Wdata = 8'h66;
        tick();
        i_Req = 1'b0;
        chk("t4_wr_before", 32'(o_Bus_Wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_wr_async", 32'(o_Bus_Wr), 32'd0);
        chk("t4_rd_async", 32'(o_Bus_Rd), 32'd0);
        chk("t4_busy_async", 32'(o_Busy), 32'd0);
        tick();
        rst_n = 1'b1;
        do_txn(1'b0, 8'h80, 8'h00, 8'h77, 1, "t4b");
        chk("t4_dato", 32'(o_Dato_Bus), 32'h77);
        tick();

`ifdef BUS_TIMEOUT_EN
        // 5: no ack -> abort after TO_CYC REQ cycles
        rd0 = rd_cnt;
        tick();
        i_Req = 1'b1; i_We = 1'b0; i_Addr = 8'h44;
        tick();
        i_Req = 1'b0;
        n = 1;
        while (o_Done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t5_done", 32'(o_Done), 32'd1);
        chk("t5_err", 32'(o_Err), 32'd1);
        chk("t5_latency", 32'(n), 32'(TO_CYC + 1));
        chk("t5_rd_cycles", 32'(rd_cnt - rd0), 32'(TO_CYC));
        chk("t5_dato", 32'(o_Dato_Bus), 32'h77);
        tick();
        chk("t5_err_hold", 32'(o_Err), 32'd1);
        do_txn(1'b1, 8'h12, 8'h34, 8'h00, 0, "t5b");
        chk("t5_err_clr", 32'(o_Err), 32'd0);
        tick();

        // 6: ack on the last allowed REQ cycle wins over the watchdog
        do_txn(1'b0, 8'h90, 8'h00, 8'hC3, TO_CYC - 1, "t6");
        chk("t6_err", 32'(o_Err), 32'd0);
        chk("t6_dato", 32'(o_Dato_Bus), 32'hC3);
        tick();
`else
        // Without the watchdog a long wait still completes normally
        rd0 = rd_cnt;
        n = 0;
        do_txn(1'b0, 8'h44, 8'h00, 8'h5C, 20, "t5n");
        chk("t5n_err", 32'(o_Err), 32'd0);
        chk("t5n_dato", 32'(o_Dato_Bus), 32'h5C);
        chk("t5n_rd_cycles", 32'(rd_cnt - rd0 + n), 32'd21);
        tick();
`endif

        // Back-to-back loads at the maximum issue rate
        do_txn(1'b0, 8'h01, 8'h00, 8'h1E, 0, "b2b0");
        do_txn(1'b0, 8'h02, 8'h00, 8'h2F, 0, "b2b1");
        chk("b2b_dato", 32'(o_Dato_Bus), 32'h2F);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bus_data_port
